rv32_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. Consumes the two source-operand values produced by the register file, together with the instruction word. Runs a 32-step shift-add multiply or restoring divide. Emits a one-cycle write-back (`wb_en`, `wb_reg`, `wb_val`) that drives the register file's write port directly.

---
 rtl/rv32_m_pkg.sv | 35 +++
 rtl/rv32_div_step.sv | 36 +++
 rtl/rv32_muldiv_unit.sv | 201 ++++++++++++++++++++
 tb/tb_rv32_muldiv_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_m_pkg.sv
// rtl/rv32_m_pkg.sv - shared constants and types for the RV32M multiply/divide unit
//
// Purpose : opcode/funct constants, FSM state type, iteration count and an
//           absolute-value helper used by rv32_muldiv_unit and rv32_div_step.
// Ports   : none (package).

package rv32_m_pkg;

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam int ITER  = 32;
   localparam int CNT_W = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // |0x80000000| stays 0x80000000, read as unsigned.
   function automatic logic [31:0] abs_val(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/rv32_div_step.sv
// rtl/rv32_div_step.sv - one combinational restoring-division step
//
// Purpose : shifts the next dividend bit into the partial remainder and
//           subtracts the divisor when it fits.
// Ports   : rem_i     partial remainder in (always < divisor_i)
//           bit_i     next dividend bit, MSB first
//           divisor_i divisor magnitude
//           rem_o     partial remainder out
//           q_o       quotient bit produced by this step
// Build   : present only when RV32_DIV_EN is defined.

`ifdef RV32_DIV_EN
module rv32_div_step
   import rv32_m_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic            bit_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic            q_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {1'b0, divisor_i};

   // shifted < 2*divisor, so a set MSB of diff means the subtraction went negative.
   assign q_o   = ~diff[XLEN];
   assign rem_o = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule
`endif

// File: rtl/rv32_muldiv_unit.sv
// rtl/rv32_muldiv_unit.sv - iterative RV32M multiply/divide unit with register write-back
//
// Purpose : accepts an OP/MULDIV instruction with its operands, runs a 32-step
//           shift-add multiply or restoring divide and issues a one-cycle write-back.
// Ports   : clk, rst (sync, active-high)
//           start, ins[31:0], rs1_val, rs2_val   request, sampled while busy=0
//           busy                                 accept edge through write-back cycle
//           wb_en, wb_reg[4:0], wb_val           registered write-back port
// Build   : RV32_DIV_EN defined -> divider datapath present, all eight funct3 codes.
//           RV32_DIV_EN undefined -> funct3[2]=1 ops complete early and write back 0.

module rv32_muldiv_unit
   import rv32_m_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [31:0]     ins,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic            busy,
   output logic            wb_en,
   output logic [4:0]      wb_reg,
   output logic [XLEN-1:0] wb_val
);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          f3_q, f3_d;
   logic [4:0]          rd_q, rd_d;
   logic                neg_q, neg_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     res_q, res_d;
   logic                wb_en_q, wb_en_d;
   logic                wb_cyc_q, wb_cyc_d;
   logic [4:0]          wb_reg_q, wb_reg_d;
   logic [XLEN-1:0]     wb_val_q, wb_val_d;

   logic [2:0]          f3_in;
   logic                accept;
   logic                s1, s2;
   logic [XLEN-1:0]     abs1, abs2;
   logic                neg_in;
   logic                special;
   logic [XLEN-1:0]     special_val;
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [2*XLEN-1:0]   iter_next;
   logic [2*XLEN-1:0]   mul_signed;
   logic [XLEN-1:0]     mul_word;
   logic [XLEN-1:0]     final_val;

   // The write-back cycle follows DONE, so busy also covers it.
   assign busy   = (state_q != IDLE) || wb_cyc_q;
   assign wb_en  = wb_en_q;
   assign wb_reg = wb_reg_q;
   assign wb_val = wb_val_q;

   assign f3_in  = ins[14:12];
   assign accept = start && !busy && (ins[6:0] == OPC_OP) && (ins[31:25] == FUNCT7_MULDIV);

   assign s1 = rs1_val[XLEN-1] && ((f3_in == F3_MULH) || (f3_in == F3_MULHSU) ||
                                   (f3_in == F3_DIV)  || (f3_in == F3_REM));
   assign s2 = rs2_val[XLEN-1] && ((f3_in == F3_MULH) || (f3_in == F3_DIV) ||
                                   (f3_in == F3_REM));
   assign abs1   = abs_val(rs1_val, s1);
   assign abs2   = abs_val(rs2_val, s2);
   // Remainder follows the dividend; everything else follows the sign product.
   assign neg_in = (f3_in == F3_REM) ? s1 : (s1 ^ s2);

   // Multiply step: acc = {partial high, remaining multiplier bits}.
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

   assign mul_signed = neg_q ? (-iter_next) : iter_next;
   assign mul_word   = (f3_q == F3_MUL) ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];

`ifdef RV32_DIV_EN
   logic [XLEN-1:0]   div_rem;
   logic              div_q;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN-1:0]   div_word;
   logic [XLEN-1:0]   div_signed;
   logic              div_by_zero;
   logic              div_ovf;

   // Divide step: acc = {partial remainder, dividend bits shifting out / quotient bits in}.
   rv32_div_step #(.XLEN(XLEN)) u_div_step (
      .rem_i     (acc_q[2*XLEN-1:XLEN]),
      .bit_i     (acc_q[XLEN-1]),
      .divisor_i (opb_q),
      .rem_o     (div_rem),
      .q_o       (div_q)
   );

   assign div_next   = {div_rem, acc_q[XLEN-2:0], div_q};
   assign iter_next  = f3_q[2] ? div_next : mul_next;
   assign div_word   = f3_q[1] ? iter_next[2*XLEN-1:XLEN] : iter_next[XLEN-1:0];
   assign div_signed = neg_q ? (-div_word) : div_word;
   assign final_val  = f3_q[2] ? div_signed : mul_word;

   assign div_by_zero = (rs2_val == '0);
   assign div_ovf     = ((f3_in == F3_DIV) || (f3_in == F3_REM)) &&
                        (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
   assign special     = f3_in[2] && (div_by_zero || div_ovf);
   assign special_val = div_by_zero ? (f3_in[1] ? rs1_val : '1)
                                    : (f3_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
`else
   assign iter_next   = mul_next;
   assign final_val   = mul_word;
   assign special     = f3_in[2];
   assign special_val = '0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      rd_d     = rd_q;
      neg_d    = neg_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      res_d    = res_q;
      wb_en_d  = 1'b0;
      wb_cyc_d = 1'b0;
      wb_reg_d = wb_reg_q;
      wb_val_d = wb_val_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               f3_d  = f3_in;
               rd_d  = ins[11:7];
               neg_d = neg_in;
               cnt_d = '0;
               if (special) begin
                  res_d   = special_val;
                  state_d = DONE;
               end else begin
                  // Multiply: multiplier in acc low, multiplicand in opb.
                  // Divide:   dividend in acc low, divisor in opb.
                  acc_d   = {{XLEN{1'b0}}, (f3_in[2] ? abs1 : abs2)};
                  opb_d   = f3_in[2] ? abs2 : abs1;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            acc_d = iter_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ITER - 1)) begin
               res_d   = final_val;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            wb_cyc_d = 1'b1;
            wb_en_d  = (rd_q != 5'd0);
            wb_reg_d = rd_q;
            wb_val_d = res_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         rd_q     <= '0;
         neg_q    <= 1'b0;
         opb_q    <= '0;
         acc_q    <= '0;
         res_q    <= '0;
         wb_en_q  <= 1'b0;
         wb_cyc_q <= 1'b0;
         wb_reg_q <= '0;
         wb_val_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         rd_q     <= rd_d;
         neg_q    <= neg_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         res_q    <= res_d;
         wb_en_q  <= wb_en_d;
         wb_cyc_q <= wb_cyc_d;
         wb_reg_q <= wb_reg_d;
         wb_val_q <= wb_val_d;
      end
   end

endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// tb/tb_rv32_muldiv_unit.sv - self-checking bench for rv32_muldiv_unit

module tb_rv32_muldiv_unit;
   import rv32_m_pkg::*;

`ifdef RV32_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] ins;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        busy;
   logic        wb_en;
   logic [4:0]  wb_reg;
   logic [31:0] wb_val;

   int checks = 0;
   int errors = 0;

   rv32_muldiv_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .ins     (ins),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .busy    (busy),
      .wb_en   (wb_en),
      .wb_reg  (wb_reg),
      .wb_val  (wb_val)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] make_ins(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [6:0] opc);
      logic [9:0] mid;
      mid = 10'($urandom);
      return {f7, mid, f3, rd, opc};
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return 1'b0;
      if (!DIV_EN) return 1'b1;
      if (b == 32'h0) return 1'b1;
      return ((f3 == 3'b100) || (f3 == 3'b110)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   endfunction

   // Architectural RV32M results computed with plain 64-bit arithmetic.
   function automatic logic [31:0] ref_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      case (f3)
         3'b000: begin p = ua * ub; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         default: begin
            if (!DIV_EN) return 32'h0;
            if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
            if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return f3[1] ? 32'h0 : 32'h8000_0000;
            case (f3)
               3'b100:  return 32'($signed(a) / $signed(b));
               3'b101:  return a / b;
               3'b110:  return 32'($signed(a) % $signed(b));
               default: return a % b;
            endcase
         end
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input bit pulse);
      int          lat, busy_cnt, wb_cnt, wb_idx;
      bit          ended;
      logic [31:0] exp_val, got_val;
      logic [4:0]  got_reg;
      exp_val  = ref_val(f3, a, b);
      lat      = is_special(f3, a, b) ? 1 : 33;
      busy_cnt = 0;
      wb_cnt   = 0;
      wb_idx   = -1;
      got_val  = 'x;
      got_reg  = 'x;
      ended    = 1'b0;
      @(negedge clk);
      start   = 1'b1;
      ins     = make_ins(7'b0000001, f3, rd, 7'b0110011);
      rs1_val = a;
      rs2_val = b;
      for (int idx = 0; idx < 80; idx++) begin
         @(negedge clk);
         if (idx == 0) begin
            start   = 1'b0;
            rs1_val = $urandom;
            rs2_val = $urandom;
         end
         if (pulse && idx == 5) begin
            start   = 1'b1;
            ins     = make_ins(7'b0000001, 3'b000, 5'd3, 7'b0110011);
            rs1_val = $urandom;
            rs2_val = $urandom;
         end
         if (pulse && idx == 6) start = 1'b0;
         if (busy) busy_cnt++;
         if (wb_en) begin
            wb_cnt++;
            wb_idx  = idx;
            got_val = wb_val;
            got_reg = wb_reg;
         end
         if (!busy) begin
            ended = 1'b1;
            break;
         end
      end
      check({tag, " ended"}, 64'(ended), 64'd1);
      check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(lat + 1));
      check({tag, " wb_count"}, 64'(wb_cnt), (rd != 5'd0) ? 64'd1 : 64'd0);
      if (rd != 5'd0) begin
         check({tag, " wb_latency"}, 64'(wb_idx), 64'(lat));
         check({tag, " wb_val"}, 64'(got_val), 64'(exp_val));
         check({tag, " wb_reg"}, 64'(got_reg), 64'(rd));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int wb_seen;
      logic [2:0] f3;
      rst     = 1'b1;
      start   = 1'b0;
      ins     = 32'h0;
      rs1_val = 32'h0;
      rs2_val = 32'h0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset wb_en", 64'(wb_en), 64'd0);
      check("reset wb_reg", 64'(wb_reg), 64'd0);
      check("reset wb_val", 64'(wb_val), 64'd0);
      rst = 1'b0;

      // Non-M instructions are ignored.
      @(negedge clk);
      start = 1'b1;
      ins   = make_ins(7'b0000000, 3'b000, 5'd4, 7'b0110011);
      @(negedge clk);
      check("ignore funct7 busy", 64'(busy), 64'd0);
      ins   = make_ins(7'b0000001, 3'b000, 5'd4, 7'b0010011);
      @(negedge clk);
      check("ignore opcode busy", 64'(busy), 64'd0);
      start = 1'b0;

      run_op("mul 7*-3",     3'b000, 5'd5,  32'd7,        32'hFFFF_FFFD, 1'b0);
      run_op("mulh min*min", 3'b001, 5'd6,  32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op("mulhu min*min",3'b011, 5'd7,  32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op("mulhsu -1*ff", 3'b010, 5'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("div -7/2",     3'b100, 5'd10, 32'hFFFF_FFF9, 32'd2,         1'b0);
      run_op("rem -7/2",     3'b110, 5'd11, 32'hFFFF_FFF9, 32'd2,         1'b0);
      run_op("divu -7/2",    3'b101, 5'd12, 32'hFFFF_FFF9, 32'd2,         1'b0);
      run_op("div 5/0",      3'b100, 5'd13, 32'd5,         32'd0,         1'b0);
      run_op("remu 5/0",     3'b111, 5'd14, 32'd5,         32'd0,         1'b0);
      run_op("div ovf",      3'b100, 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("start while busy", 3'b000, 5'd16, 32'h1234,  32'h5678,      1'b1);
      run_op("rd0",          3'b000, 5'd0,  32'd9,         32'd9,         1'b0);

      // Reset abort in cycle 10 of a MUL.
      @(negedge clk);
      start   = 1'b1;
      ins     = make_ins(7'b0000001, 3'b000, 5'd20, 7'b0110011);
      rs1_val = 32'd100;
      rs2_val = 32'd200;
      for (int idx = 0; idx < 10; idx++) begin
         @(negedge clk);
         if (idx == 0) start = 1'b0;
         if (idx == 9) rst = 1'b1;
      end
      @(negedge clk);
      check("abort busy", 64'(busy), 64'd0);
      check("abort wb_en", 64'(wb_en), 64'd0);
      check("abort wb_reg", 64'(wb_reg), 64'd0);
      check("abort wb_val", 64'(wb_val), 64'd0);
      rst = 1'b0;
      wb_seen = 0;
      for (int idx = 0; idx < 50; idx++) begin
         @(negedge clk);
         if (wb_en) wb_seen++;
      end
      check("abort no wb", 64'(wb_seen), 64'd0);
      run_op("mul 3*4 after abort", 3'b000, 5'd21, 32'd3, 32'd4, 1'b0);

      for (int n = 0; n < 40; n++) begin
         f3 = 3'($urandom_range(0, 7));
         run_op($sformatf("rand%0d f3=%0d", n, f3), f3, 5'($urandom_range(1, 31)),
                pick_operand(), pick_operand(), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
